// File: rtl/mdu_unit_if.sv
// E-stage <-> multiply/divide unit bundle: operands, op select, start strobe,
// and the busy/HI/LO values returned to the stall controller and result mux.
interface mdu_unit_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDUOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output A, B, MDUOp, Start, input Busy, HI, LO);
  modport slave  (input A, B, MDUOp, Start, output Busy, HI, LO);
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle MIPS multiply/divide unit holding HI/LO. Latency comes from a
// down-counter; the arithmetic is combinational on captured operands.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    mdu_unit_if.slave   bus,
    output logic        state_dbg
);

    // Handshake: Start qualifies MDUOp on a rising edge only while Busy=0.
    // A start seen while Busy=1 is dropped; the stall controller is expected
    // to hold the front end off while Busy is high.

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] hi_q, lo_q;
    logic        capture, commit, wr_hi, wr_lo;

    logic        is_mul_op, is_div_op;
    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

    assign is_mul_op = (bus.MDUOp == OP_MULT) || (bus.MDUOp == OP_MULTU);
    assign is_div_op = (bus.MDUOp == OP_DIV)  || (bus.MDUOp == OP_DIVU);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        capture = 1'b0;
        commit  = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Start && (is_mul_op || is_div_op)) begin
                    state_d = BUSY;
                    cnt_d   = is_mul_op ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                    capture = 1'b1;
                end else if (bus.Start && bus.MDUOp == OP_MTHI) begin
                    wr_hi = 1'b1;
                end else if (bus.Start && bus.MDUOp == OP_MTLO) begin
                    wr_lo = 1'b1;
                end
            end
            BUSY: begin
                if (cnt <= 4'd1) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Signed divide via magnitudes: handles 0x80000000 / -1 without overflow
    // traps and gives a remainder carrying the dividend's sign.
    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        a_neg  = (op_q == OP_DIV) && a_q[31];
        b_neg  = (op_q == OP_DIV) && b_q[31];
        a_mag  = a_neg ? (32'd0 - a_q) : a_q;
        b_mag  = b_neg ? (32'd0 - b_q) : b_q;
        q_mag  = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
        r_mag  = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
        quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem    = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            op_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (capture) begin
                op_q <= bus.MDUOp;
                a_q  <= bus.A;
                b_q  <= bus.B;
            end
            if (commit) begin
                case (op_q)
                    OP_MULT:  {hi_q, lo_q} <= prod_s;
                    OP_MULTU: {hi_q, lo_q} <= prod_u;
                    OP_DIV, OP_DIVU: begin
                        // Divide by zero leaves HI/LO untouched.
                        if (b_q != 32'd0) begin
                            hi_q <= rem;
                            lo_q <= quot;
                        end
                    end
                    default: ;
                endcase
            end
            if (wr_hi) hi_q <= bus.A;
            if (wr_lo) lo_q <= bus.A;
        end
    end

    assign bus.Busy  = (state == BUSY);
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;
    assign state_dbg = (state == BUSY);

endmodule
